// File: rtl/rs_syndrome_calc_if.sv
// Symbol stream in, syndrome vector out, for the RS(31,k) syndrome stage.
// The producer of received symbols drives the master side.
interface rs_syndrome_calc_if #(
    parameter int T = 4
);
    logic              start;
    logic              symbol_valid;
    logic [4:0]        symbol_in;
    logic              busy;
    logic              synd_valid;
    logic [10*T-1:0]   syndromes;
    logic              synd_nonzero;

    modport master (
        output start, symbol_valid, symbol_in,
        input  busy, synd_valid, syndromes, synd_nonzero
    );

    modport slave (
        input  start, symbol_valid, symbol_in,
        output busy, synd_valid, syndromes, synd_nonzero
    );
endinterface

// File: rtl/rs_syndrome_calc.sv
// Syndrome calculator for RS(31,31-2T) over GF(2^5), p(x) = x^5 + x^2 + 1.
// Horner-evaluates the received polynomial at alpha^FCR .. alpha^(FCR+2T-1).
module rs_syndrome_calc #(
    parameter int T   = 4,
    parameter int FCR = 1
) (
    input logic               clock,
    input logic               reset_n,
    rs_syndrome_calc_if.slave bus
);

    localparam int NSYND = 2 * T;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        DONE
    } state_t;

    state_t state, state_next;

    logic [4:0]         count;
    logic [4:0]         acc    [NSYND];
    logic [4:0]         horner [NSYND];
    logic [10*T-1:0]    horner_flat;
    logic [10*T-1:0]    synd_reg;
    logic               nonzero_reg;
    logic               take_start;
    logic               take_symbol;
    logic               last_symbol;

    // One multiply by alpha: shift, then fold alpha^5 back as alpha^2 + 1.
    function automatic logic [4:0] mul_alpha(input logic [4:0] a);
        return {a[3:0], 1'b0} ^ (a[4] ? 5'b00101 : 5'b00000);
    endfunction

    function automatic logic [4:0] mul_alpha_pow(input logic [4:0] a, input int k);
        logic [4:0] r;
        r = a;
        for (int i = 0; i < k; i++) begin
            r = mul_alpha(r);
        end
        return r;
    endfunction

    assign take_start  = bus.start & bus.symbol_valid;
    assign take_symbol = (state == ACCUM) & bus.symbol_valid & ~bus.start;
    assign last_symbol = take_symbol & (count == 5'd30);

    for (genvar j = 0; j < NSYND; j++) begin : g_horner
        localparam int EXPO = (((FCR + j) % 31) + 31) % 31;
        assign horner[j]              = mul_alpha_pow(acc[j], EXPO) ^ bus.symbol_in;
        assign horner_flat[5*j +: 5]  = horner[j];
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A start in any state begins a new frame; DONE lasts exactly one cycle.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (take_start) begin
                    state_next = ACCUM;
                end
            end
            ACCUM: begin
                if (take_start) begin
                    state_next = ACCUM;
                end else if (last_symbol) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = take_start ? ACCUM : IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count <= 5'd0;
            for (int j = 0; j < NSYND; j++) begin
                acc[j] <= 5'd0;
            end
        end else if (take_start) begin
            count <= 5'd1;
            for (int j = 0; j < NSYND; j++) begin
                acc[j] <= bus.symbol_in;
            end
        end else if (take_symbol) begin
            count <= count + 5'd1;
            for (int j = 0; j < NSYND; j++) begin
                acc[j] <= horner[j];
            end
        end
    end

    // The result is captured straight from the Horner network on the r0 edge,
    // so it is visible in the DONE cycle without an extra register stage.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            synd_reg    <= '0;
            nonzero_reg <= 1'b0;
        end else if (last_symbol) begin
            synd_reg    <= horner_flat;
            nonzero_reg <= |horner_flat;
        end
    end

    assign bus.busy         = (state == ACCUM);
    assign bus.synd_valid   = (state == DONE);
    assign bus.syndromes    = synd_reg;
    assign bus.synd_nonzero = nonzero_reg;

endmodule
